// File: rtl/gpio_bank_ctrl.sv
// Two-bank memory-mapped GPIO controller.
// - Pad outputs come straight from the OUT/OE registers.
// - Pad inputs pass through a 2-flop synchroniser.
// - Selected pin edges set sticky IRQ_STAT bits, cleared by writing 1 (W1C).
// - The level interrupt is the OR of enabled status bits, registered.
module gpio_bank_ctrl #(
   parameter int b0_bw = 8,
   parameter int b1_bw = 8,
   parameter int aw    = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_i,
   input  logic              we_i,
   input  logic [aw-1:0]     addr_i,
   input  logic [31:0]       wdata_i,
   output logic [31:0]       rdata_o,
   output logic              ack_o,
   output logic [b0_bw-1:0]  b0_data_o,
   output logic [b0_bw-1:0]  b0_oe_o,
   input  logic [b0_bw-1:0]  b0_data_i,
   output logic [b1_bw-1:0]  b1_data_o,
   output logic [b1_bw-1:0]  b1_oe_o,
   input  logic [b1_bw-1:0]  b1_data_i,
   output logic              irq_o
);

   localparam int TW = b0_bw + b1_bw;

   localparam logic [aw-1:0] A_B0_OUT   = aw'(4'd0);
   localparam logic [aw-1:0] A_B0_OE    = aw'(4'd1);
   localparam logic [aw-1:0] A_B0_IN    = aw'(4'd2);
   localparam logic [aw-1:0] A_B1_OUT   = aw'(4'd3);
   localparam logic [aw-1:0] A_B1_OE    = aw'(4'd4);
   localparam logic [aw-1:0] A_B1_IN    = aw'(4'd5);
   localparam logic [aw-1:0] A_IRQ_EN   = aw'(4'd6);
   localparam logic [aw-1:0] A_IRQ_STAT = aw'(4'd7);
   localparam logic [aw-1:0] A_EDGE_SEL = aw'(4'd8);

   logic [b0_bw-1:0] r_b0_out;
   logic [b0_bw-1:0] r_b0_oe;
   logic [b1_bw-1:0] r_b1_out;
   logic [b1_bw-1:0] r_b1_oe;
   logic [TW-1:0]    r_irq_en;
   logic [TW-1:0]    r_irq_stat;
   logic [TW-1:0]    r_edge_sel;
   logic [TW-1:0]    r_sync1;
   logic [TW-1:0]    r_sync2;
   logic [TW-1:0]    r_prev;
   logic             r_ack;
   logic [31:0]      r_rdata;
   logic             r_irq;

   logic             w_wr;
   logic             w_rd;
   logic [TW-1:0]    w_rise;
   logic [TW-1:0]    w_fall;
   logic [TW-1:0]    w_set;
   logic [TW-1:0]    w_clr;
   logic [TW-1:0]    w_stat_nxt;
   logic [31:0]      w_rdata;
   logic             w_unused_ok;

   assign w_wr = req_i & we_i;
   assign w_rd = req_i & ~we_i;

   // Upper write-data bits beyond the widest field are intentionally ignored.
   assign w_unused_ok = &{1'b0, wdata_i};

   // Edge detection against prev; set beats a same-cycle W1C on the same bit.
   always_comb begin
      w_rise = r_sync2 & ~r_prev;
      w_fall = ~r_sync2 & r_prev;
      w_set  = (w_rise & r_edge_sel) | (w_fall & ~r_edge_sel);
      if (w_wr && (addr_i == A_IRQ_STAT)) begin
         w_clr = wdata_i[TW-1:0];
      end else begin
         w_clr = '0;
      end
      w_stat_nxt = (r_irq_stat & ~w_clr) | w_set;
   end

   // Read mux: fields zero-extended into the low bits, unmapped indices read 0.
   always_comb begin
      w_rdata = 32'd0;
      if (w_rd) begin
         case (addr_i)
            A_B0_OUT:   w_rdata[b0_bw-1:0] = r_b0_out;
            A_B0_OE:    w_rdata[b0_bw-1:0] = r_b0_oe;
            A_B0_IN:    w_rdata[b0_bw-1:0] = r_sync2[b0_bw-1:0];
            A_B1_OUT:   w_rdata[b1_bw-1:0] = r_b1_out;
            A_B1_OE:    w_rdata[b1_bw-1:0] = r_b1_oe;
            A_B1_IN:    w_rdata[b1_bw-1:0] = r_sync2[TW-1:b0_bw];
            A_IRQ_EN:   w_rdata[TW-1:0]    = r_irq_en;
            A_IRQ_STAT: w_rdata[TW-1:0]    = r_irq_stat;
            A_EDGE_SEL: w_rdata[TW-1:0]    = r_edge_sel;
            default:    w_rdata            = 32'd0;
         endcase
      end else begin
         w_rdata = 32'd0;
      end
   end

   // Bus response: one-cycle ack after every request, read data only with ack.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ack   <= 1'b0;
         r_rdata <= 32'd0;
      end else begin
         r_ack   <= req_i;
         r_rdata <= w_rdata;
      end
   end

   // Read/write configuration registers; writes to read-only or unmapped indices are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_b0_out   <= '0;
         r_b0_oe    <= '0;
         r_b1_out   <= '0;
         r_b1_oe    <= '0;
         r_irq_en   <= '0;
         r_edge_sel <= '0;
      end else if (w_wr) begin
         case (addr_i)
            A_B0_OUT:   r_b0_out   <= wdata_i[b0_bw-1:0];
            A_B0_OE:    r_b0_oe    <= wdata_i[b0_bw-1:0];
            A_B1_OUT:   r_b1_out   <= wdata_i[b1_bw-1:0];
            A_B1_OE:    r_b1_oe    <= wdata_i[b1_bw-1:0];
            A_IRQ_EN:   r_irq_en   <= wdata_i[TW-1:0];
            A_EDGE_SEL: r_edge_sel <= wdata_i[TW-1:0];
            default:    ;
         endcase
      end
   end

   // Two-flop synchroniser for the asynchronous pads, plus the prev stage for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_prev  <= '0;
      end else begin
         r_sync1 <= {b1_data_i, b0_data_i};
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   // Sticky interrupt status; bits are set whether or not they are enabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_irq_stat <= '0;
      end else begin
         r_irq_stat <= w_stat_nxt;
      end
   end

   // Registered level interrupt, one cycle behind the status/enable registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_irq <= 1'b0;
      end else begin
         r_irq <= |(r_irq_stat & r_irq_en);
      end
   end

   assign ack_o     = r_ack;
   assign rdata_o   = r_rdata;
   assign irq_o     = r_irq;
   assign b0_data_o = r_b0_out;
   assign b0_oe_o   = r_b0_oe;
   assign b1_data_o = r_b1_out;
   assign b1_oe_o   = r_b1_oe;

endmodule

// File: tb/tb_gpio_bank_ctrl.sv
// Directed bench for gpio_bank_ctrl.
// - A register-map model predicts every output and is checked on each falling edge.
// - Hand-computed literal checks pin the model's expectations.
module tb_gpio_bank_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_i = 1'b0;
   logic        we_i = 1'b0;
   logic [3:0]  addr_i = 4'd0;
   logic [31:0] wdata_i = 32'd0;
   logic [31:0] rdata_o;
   logic        ack_o;
   logic [7:0]  b0_data_o, b0_oe_o, b1_data_o, b1_oe_o;
   logic [7:0]  b0_data_i = 8'h00;
   logic [7:0]  b1_data_i = 8'h00;
   logic        irq_o;

   int n_vec = 0;
   int n_err = 0;

   gpio_bank_ctrl #(.b0_bw(8), .b1_bw(8), .aw(4)) dut (
      .clk(clk), .rst_n(rst_n), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
      .wdata_i(wdata_i), .rdata_o(rdata_o), .ack_o(ack_o),
      .b0_data_o(b0_data_o), .b0_oe_o(b0_oe_o), .b0_data_i(b0_data_i),
      .b1_data_o(b1_data_o), .b1_oe_o(b1_oe_o), .b1_data_i(b1_data_i),
      .irq_o(irq_o)
   );

   always #5 clk = ~clk;

   // Model state: register words by index, and the pad values seen at the last three edges.
   logic [31:0] m_reg [0:8];
   logic [15:0] hist  [0:2];
   logic        e_ack, e_irq;
   logic [31:0] e_rdata;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_read(input logic [3:0] a);
      case (a)
         4'd2:    return {24'd0, hist[1][7:0]};
         4'd5:    return {24'd0, hist[1][15:8]};
         4'd0, 4'd1, 4'd3, 4'd4, 4'd6, 4'd7, 4'd8: return m_reg[a];
         default: return 32'd0;
      endcase
   endfunction

   // Behavioural model: what every output must be after each edge.
   always @(posedge clk or negedge rst_n) begin : model
      logic [15:0] ev;
      logic [31:0] st;
      if (!rst_n) begin
         for (int i = 0; i < 9; i++) m_reg[i] <= 32'd0;
         for (int i = 0; i < 3; i++) hist[i] <= 16'd0;
         e_ack <= 1'b0; e_rdata <= 32'd0; e_irq <= 1'b0;
      end else begin
         e_irq   <= ((m_reg[7] & m_reg[6]) != 32'd0);
         e_ack   <= req_i;
         e_rdata <= (req_i && !we_i) ? m_read(addr_i) : 32'd0;
         // A pin fires when its synchronised value changed to the level EDGE_SEL asks for.
         ev = 16'd0;
         for (int i = 0; i < 16; i++)
            if (hist[1][i] != hist[2][i] && hist[1][i] == m_reg[8][i]) ev[i] = 1'b1;
         st = m_reg[7];
         if (req_i && we_i) begin
            case (addr_i)
               4'd0, 4'd1, 4'd3, 4'd4: m_reg[addr_i] <= wdata_i & 32'h0000_00FF;
               4'd6, 4'd8:             m_reg[addr_i] <= wdata_i & 32'h0000_FFFF;
               4'd7:                   st = st & ~wdata_i;
               default: ;
            endcase
         end
         m_reg[7] <= (st | {16'd0, ev}) & 32'h0000_FFFF;
         hist[2] <= hist[1];
         hist[1] <= hist[0];
         hist[0] <= {b1_data_i, b0_data_i};
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      chk("ack_o", {31'd0, ack_o}, {31'd0, e_ack});
      chk("rdata_o", rdata_o, e_rdata);
      chk("irq_o", {31'd0, irq_o}, {31'd0, e_irq});
      chk("b0_data_o", {24'd0, b0_data_o}, m_reg[0]);
      chk("b0_oe_o", {24'd0, b0_oe_o}, m_reg[1]);
      chk("b1_data_o", {24'd0, b1_data_o}, m_reg[3]);
      chk("b1_oe_o", {24'd0, b1_oe_o}, m_reg[4]);
   end

   task automatic cyc(input logic rq, input logic w, input logic [3:0] a, input logic [31:0] d);
      @(posedge clk);
      #1;
      req_i = rq; we_i = w; addr_i = a; wdata_i = d;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b0, 1'b0, 4'd0, 32'd0);
   endtask

   task automatic rd_chk(input logic [3:0] a, input logic [31:0] exp, input string nm);
      cyc(1'b1, 1'b0, a, 32'd0);
      cyc(1'b0, 1'b0, 4'd0, 32'd0);
      @(negedge clk);
      chk({nm, "_ack"}, {31'd0, ack_o}, 32'd1);
      chk(nm, rdata_o, exp);
   endtask

   // Directed stimulus with literal expectations.
   initial begin
      rst_n = 1'b0;
      idle(3);
      rst_n = 1'b1;
      idle(2);

      // Reset asserted in the middle of a write to B0_OE.
      cyc(1'b1, 1'b1, 4'd1, 32'h0000_00FF);
      #2 rst_n = 1'b0;
      idle(2);
      @(negedge clk);
      chk("rst_b0_oe", {24'd0, b0_oe_o}, 32'd0);
      chk("rst_ack", {31'd0, ack_o}, 32'd0);
      cyc(1'b0, 1'b0, 4'd0, 32'd0);
      rst_n = 1'b1;
      idle(1);
      rd_chk(4'd1, 32'd0, "rst_rd_b0_oe");

      // Write / readback.
      cyc(1'b1, 1'b1, 4'd0, 32'hFFFF_FFA5);
      cyc(1'b1, 1'b1, 4'd1, 32'h0000_000F);
      cyc(1'b1, 1'b1, 4'd3, 32'h0000_003C);
      cyc(1'b1, 1'b1, 4'd9, 32'hDEAD_BEEF);
      cyc(1'b0, 1'b0, 4'd0, 32'd0);
      @(negedge clk);
      chk("pad_b0_data", {24'd0, b0_data_o}, 32'h0000_00A5);
      chk("pad_b0_oe", {24'd0, b0_oe_o}, 32'h0000_000F);
      rd_chk(4'd0, 32'h0000_00A5, "rd_b0_out");
      rd_chk(4'd1, 32'h0000_000F, "rd_b0_oe");
      rd_chk(4'd3, 32'h0000_003C, "rd_b1_out");
      rd_chk(4'd12, 32'd0, "rd_idx12");
      rd_chk(4'd9, 32'd0, "rd_idx9");

      // Input synchroniser latency: pad change in cycle N readable from N+2.
      cyc(1'b0, 1'b0, 4'd0, 32'd0);
      b1_data_i = 8'h81;
      cyc(1'b1, 1'b0, 4'd5, 32'd0);
      cyc(1'b1, 1'b0, 4'd5, 32'd0);
      @(negedge clk);
      chk("b1_in_early", rdata_o, 32'd0);
      cyc(1'b0, 1'b0, 4'd0, 32'd0);
      @(negedge clk);
      chk("b1_in_late", rdata_o, 32'h0000_0081);
      b1_data_i = 8'h00;
      idle(5);
      cyc(1'b1, 1'b1, 4'd7, 32'h0000_FFFF);
      idle(1);
      rd_chk(4'd7, 32'd0, "stat_cleared");

      // Rising edge on bank 1 pin 0 with rising selected and enabled.
      cyc(1'b1, 1'b1, 4'd8, 32'h0000_0100);
      cyc(1'b1, 1'b1, 4'd6, 32'h0000_0100);
      cyc(1'b0, 1'b0, 4'd0, 32'd0);
      b1_data_i = 8'h01;
      idle(2);
      @(negedge clk);
      chk("irq_before", {31'd0, irq_o}, 32'd0);
      cyc(1'b1, 1'b0, 4'd7, 32'd0);
      @(negedge clk);
      chk("irq_n3", {31'd0, irq_o}, 32'd0);
      cyc(1'b0, 1'b0, 4'd0, 32'd0);
      @(negedge clk);
      chk("stat_n3", rdata_o, 32'h0000_0100);
      chk("irq_n4", {31'd0, irq_o}, 32'd1);
      cyc(1'b1, 1'b1, 4'd7, 32'h0000_0100);
      idle(1);
      b1_data_i = 8'h00;
      idle(5);
      rd_chk(4'd7, 32'd0, "fall_no_set");

      // W1C racing a new set on bank 0 pin 0: set wins.
      cyc(1'b1, 1'b1, 4'd8, 32'h0000_0103);
      cyc(1'b1, 1'b1, 4'd6, 32'h0000_0103);
      cyc(1'b0, 1'b0, 4'd0, 32'd0);
      b0_data_i = 8'h03;
      idle(5);
      b0_data_i = 8'h02;
      idle(5);
      rd_chk(4'd7, 32'h0000_0003, "stat_pre_race");
      cyc(1'b0, 1'b0, 4'd0, 32'd0);
      b0_data_i = 8'h03;
      cyc(1'b0, 1'b0, 4'd0, 32'd0);
      cyc(1'b1, 1'b1, 4'd7, 32'h0000_0001);
      idle(1);
      rd_chk(4'd7, 32'h0000_0003, "stat_race");
      cyc(1'b1, 1'b1, 4'd7, 32'h0000_0003);
      cyc(1'b0, 1'b0, 4'd0, 32'd0);
      @(negedge clk);
      chk("irq_hold", {31'd0, irq_o}, 32'd1);
      cyc(1'b0, 1'b0, 4'd0, 32'd0);
      @(negedge clk);
      chk("irq_drop", {31'd0, irq_o}, 32'd0);
      rd_chk(4'd7, 32'd0, "stat_w1c");

      // Back-to-back requests.
      cyc(1'b1, 1'b1, 4'd3, 32'h0000_005A);
      cyc(1'b1, 1'b0, 4'd3, 32'd0);
      @(negedge clk);
      chk("b2b_ack1", {31'd0, ack_o}, 32'd1);
      cyc(1'b1, 1'b1, 4'd4, 32'h0000_00F0);
      @(negedge clk);
      chk("b2b_ack2", {31'd0, ack_o}, 32'd1);
      chk("b2b_rd_out", rdata_o, 32'h0000_005A);
      cyc(1'b1, 1'b0, 4'd4, 32'd0);
      @(negedge clk);
      chk("b2b_ack3", {31'd0, ack_o}, 32'd1);
      cyc(1'b0, 1'b0, 4'd0, 32'd0);
      @(negedge clk);
      chk("b2b_ack4", {31'd0, ack_o}, 32'd1);
      chk("b2b_rd_oe", rdata_o, 32'h0000_00F0);
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
